// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared types and constants for the load/store unit: FSM state
//           encoding, RV64 funct3 load/store size codes, memory-word geometry
//           (MEM_STEPS byte lanes, OFS offset bits) and size/legality helpers.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN      = 64;
    localparam int BYTE_SIZE = 8;
    localparam int MEM_STEPS = XLEN / 8;
    localparam int OFS       = $clog2(MEM_STEPS);
    // Width of a bit-shift amount that moves data by up to MEM_STEPS-1 lanes.
    localparam int SHW       = $clog2(XLEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes (1, 2, 4 or 8); the low two funct3 bits are log2(size).
    function automatic logic [OFS:0] size_bytes(input logic [2:0] funct3);
        logic [OFS:0] size;
        size = '0;
        size[funct3[1:0]] = 1'b1;
        return size;
    endfunction

    // 111 is never legal; unsigned variants exist only for loads.
    function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
        return (funct3 == 3'b111) || (store && funct3[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational lane alignment for the load/store unit.
//           Store side: masks store data to the access size and shifts data and
//           byte strobes up by the byte offset across a two-word window (low
//           word = beat 0, high word = beat 1).
//           Load side: shifts the two-word window down by the byte offset and
//           zero/sign extends the result per funct3.
// Ports   : i_funct3        access type
//           i_offset        byte offset within the first word
//           i_st_wdata      right-justified store data
//           o_st_data_wide  lane-shifted store data, {beat1, beat0}
//           o_st_strb_wide  lane-shifted byte strobes, {beat1, beat0}
//           i_ld_lo_word    first (or only) loaded word
//           i_ld_hi_word    second loaded word (split loads)
//           o_ld_result     extended load result
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]             i_funct3,
    input  logic [OFS-1:0]         i_offset,
    input  logic [XLEN-1:0]        i_st_wdata,
    output logic [2*XLEN-1:0]      o_st_data_wide,
    output logic [2*MEM_STEPS-1:0] o_st_strb_wide,
    input  logic [XLEN-1:0]        i_ld_lo_word,
    input  logic [XLEN-1:0]        i_ld_hi_word,
    output logic [XLEN-1:0]        o_ld_result
);

    localparam int c_half_w = 2 * BYTE_SIZE;
    localparam int c_word_w = 4 * BYTE_SIZE;

    logic [OFS:0]         w_size;
    logic [SHW-1:0]       w_shift;
    logic [MEM_STEPS-1:0] w_mask;
    logic [XLEN-1:0]      w_wdata_m;
    logic [2*XLEN-1:0]    w_ld_wide;
    logic [XLEN-1:0]      w_raw;

    assign w_size  = size_bytes(i_funct3);
    // BYTE_SIZE is a power of two, so the bit shift is the offset with zero LSBs.
    assign w_shift = {i_offset, {$clog2(BYTE_SIZE){1'b0}}};

    always_comb begin
        w_mask    = '0;
        w_wdata_m = '0;
        for (int i = 0; i < MEM_STEPS; i++) begin
            if (i < int'(w_size)) begin
                w_mask[i]                            = 1'b1;
                w_wdata_m[i*BYTE_SIZE +: BYTE_SIZE]  = i_st_wdata[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    assign o_st_strb_wide = {{MEM_STEPS{1'b0}}, w_mask} << i_offset;
    assign o_st_data_wide = {{XLEN{1'b0}}, w_wdata_m} << w_shift;

    // Bytes above the access size that leak in from the window are discarded
    // by the extension below.
    assign w_ld_wide = {i_ld_hi_word, i_ld_lo_word} >> w_shift;
    assign w_raw     = w_ld_wide[XLEN-1:0];

    always_comb begin
        o_ld_result = '0;
        case (i_funct3)
            F3_B:    o_ld_result = {{(XLEN-BYTE_SIZE){w_raw[BYTE_SIZE-1]}}, w_raw[BYTE_SIZE-1:0]};
            F3_H:    o_ld_result = {{(XLEN-c_half_w){w_raw[c_half_w-1]}}, w_raw[c_half_w-1:0]};
            F3_W:    o_ld_result = {{(XLEN-c_word_w){w_raw[c_word_w-1]}}, w_raw[c_word_w-1:0]};
            F3_D:    o_ld_result = w_raw;
            F3_BU:   o_ld_result = {{(XLEN-BYTE_SIZE){1'b0}}, w_raw[BYTE_SIZE-1:0]};
            F3_HU:   o_ld_result = {{(XLEN-c_half_w){1'b0}}, w_raw[c_half_w-1:0]};
            F3_WU:   o_ld_result = {{(XLEN-c_word_w){1'b0}}, w_raw[c_word_w-1:0]};
            default: o_ld_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Purpose : Pipeline-side initiator for the word-wide data memory. Accepts one
//           RV64 load/store per request, issues one or two memory beats,
//           merges/extends load data and returns a one-cycle response.
// Ports   : clk, rst_n (async active-low)
//           req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata  request
//           resp_valid/resp_rdata/resp_fault                              response
//           mem_read_enable/mem_read_addr/mem_read_data                   read beat
//           mem_write_enable/mem_write_addr/mem_write_data/mem_write_strb write beat
// Config  : LSU_MISALIGNED_SPLIT_EN - when defined, accesses crossing a word
//           boundary are split into two beats; otherwise they fault.
// Revision: 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_fault,
    output logic                 mem_read_enable,
    output logic [XLEN-1:0]      mem_read_addr,
    input  logic [XLEN-1:0]      mem_read_data,
    output logic                 mem_write_enable,
    output logic [XLEN-1:0]      mem_write_addr,
    output logic [XLEN-1:0]      mem_write_data,
    output logic [MEM_STEPS-1:0] mem_write_strb
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic c_split_en = 1'b1;
`else
    localparam logic c_split_en = 1'b0;
`endif

    localparam logic [OFS:0]         c_mem_steps = MEM_STEPS;
    localparam logic [XLEN-OFS-1:0]  c_word_one  = 1;

    lsu_state_e       state_q, state_d;
    logic             store_q, store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             split_q, split_d;
    logic [XLEN-1:0]  buf_q, buf_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             fault_q, fault_d;

    logic [OFS:0]            w_req_end;
    logic                    w_req_split;
    logic                    w_req_fault;
    logic [XLEN-OFS-1:0]     w_word0;
    logic [XLEN-OFS-1:0]     w_word1;
    logic [2*XLEN-1:0]       w_st_data_wide;
    logic [2*MEM_STEPS-1:0]  w_st_strb_wide;
    logic [XLEN-1:0]         w_ld_lo;
    logic [XLEN-1:0]         w_ld_result;

    // Decode on the live request so a fault can skip the beats entirely.
    assign w_req_end   = {1'b0, req_addr[OFS-1:0]} + size_bytes(req_funct3);
    assign w_req_split = (w_req_end > c_mem_steps);
    assign w_req_fault = funct3_illegal(req_store, req_funct3) || (w_req_split && !c_split_en);

    // Second word index wraps naturally at the top of the word space.
    assign w_word0 = addr_q[XLEN-1:OFS];
    assign w_word1 = w_word0 + c_word_one;

    // For a split load the first word was parked in buf_q during BEAT1.
    assign w_ld_lo = split_q ? buf_q : mem_read_data;

    lsu_align u_align (
        .i_funct3       (funct3_q),
        .i_offset       (addr_q[OFS-1:0]),
        .i_st_wdata     (wdata_q),
        .o_st_data_wide (w_st_data_wide),
        .o_st_strb_wide (w_st_strb_wide),
        .i_ld_lo_word   (w_ld_lo),
        .i_ld_hi_word   (mem_read_data),
        .o_ld_result    (w_ld_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            split_q  <= 1'b0;
            buf_q    <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            split_q  <= split_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        store_d          = store_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        split_d          = split_q;
        buf_d            = buf_q;
        rdata_d          = rdata_q;
        fault_d          = fault_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_read_enable  = 1'b0;
        mem_read_addr    = '0;
        mem_write_enable = 1'b0;
        mem_write_addr   = '0;
        mem_write_data   = '0;
        mem_write_strb   = '0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                rdata_d   = '0;
                fault_d   = 1'b0;
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    split_d  = w_req_split && !w_req_fault;
                    if (w_req_fault) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (store_q) begin
                    mem_write_enable = 1'b1;
                    mem_write_addr   = {{OFS{1'b0}}, w_word0};
                    mem_write_data   = w_st_data_wide[XLEN-1:0];
                    mem_write_strb   = w_st_strb_wide[MEM_STEPS-1:0];
                end else begin
                    mem_read_enable  = 1'b1;
                    mem_read_addr    = {{OFS{1'b0}}, w_word0};
                end
                if (split_q && c_split_en) begin
                    state_d = BEAT1;
                end else if (store_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            BEAT1: begin
                if (store_q) begin
                    mem_write_enable = 1'b1;
                    mem_write_addr   = {{OFS{1'b0}}, w_word1};
                    mem_write_data   = w_st_data_wide[2*XLEN-1:XLEN];
                    mem_write_strb   = w_st_strb_wide[2*MEM_STEPS-1:MEM_STEPS];
                    state_d          = RESP;
                end else begin
                    mem_read_enable  = 1'b1;
                    mem_read_addr    = {{OFS{1'b0}}, w_word1};
                    buf_d            = mem_read_data;
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                rdata_d = w_ld_result;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

endmodule
`default_nettype wire
